// File: rtl/mealy_seq_detector_if.sv
// Serial-bit and match-report bundle between a bit source and the Mealy sequence detector.
// The master is the source/controller side; the slave is the detector.
interface mealy_seq_detector_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned PRE_W = 2
);
  logic             en;
  logic             x;
  logic             clr;
  logic             z;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;
  logic [PRE_W-1:0] prefix;

  modport master (
    output en,
    output x,
    output clr,
    input  z,
    input  match_cnt,
    input  cnt_sat,
    input  prefix
  );

  modport slave (
    input  en,
    input  x,
    input  clr,
    output z,
    output match_cnt,
    output cnt_sat,
    output prefix
  );
endinterface

// File: rtl/mealy_seq_detector.sv
// Parametrised Mealy detector for a PAT_W-bit pattern (MSB first) on a serial stream,
// with overlap selection, qualifying enable, synchronous clear and a saturating match counter.
module mealy_seq_detector #(
  parameter int unsigned PAT_W   = 4,
  parameter              PATTERN = 4'b1011,
  parameter bit          OVERLAP = 1'b1,
  parameter int unsigned CNT_W   = 8
) (
  input logic                 clk,
  input logic                 rst,
  mealy_seq_detector_if.slave bus
);

  localparam int unsigned SW    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int unsigned TBL_W = 2 * PAT_W * SW;
  localparam logic [PAT_W-1:0] PAT  = PAT_W'(PATTERN);
  localparam logic [SW-1:0]    LAST = SW'(PAT_W - 1);

  if (PAT_W < 2 || PAT_W > 16) begin : g_bad_width
    $error("mealy_seq_detector: PAT_W must be in 2..16");
  end
  if ((PATTERN >> PAT_W) != 0) begin : g_bad_pattern
    $error("mealy_seq_detector: PATTERN is wider than PAT_W");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("mealy_seq_detector: CNT_W must be at least 1");
  end

  // i-th bit of the pattern in arrival order (i = 0 is received first)
  function automatic logic pbit(input int unsigned i);
    logic [PAT_W-1:0] t;
    t = PAT >> (PAT_W - 1 - i);
    return t[0];
  endfunction

  // Pattern in arrival order, so the expected bit for state s is REV[s]
  function automatic logic [PAT_W-1:0] build_rev();
    logic [PAT_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      r = r | (PAT_W'(pbit(i)) << i);
    end
    return r;
  endfunction

  // Longest proper border of the whole pattern
  function automatic int unsigned border();
    bit ok;
    for (int unsigned k = PAT_W - 1; k > 0; k--) begin
      ok = 1'b1;
      for (int unsigned j = 0; j < k; j++) begin
        if (pbit(j) != pbit(PAT_W - k + j)) ok = 1'b0;
      end
      if (ok) return k;
    end
    return 0;
  endfunction

  // Longest k <= s whose pattern prefix equals the tail of (first s pattern bits, then b)
  function automatic int unsigned fallback(input int unsigned s, input logic b);
    bit   ok;
    logic tb;
    for (int unsigned k = s; k > 0; k--) begin
      ok = 1'b1;
      for (int unsigned j = 0; j < k; j++) begin
        tb = (s + 1 - k + j == s) ? b : pbit(s + 1 - k + j);
        if (pbit(j) != tb) ok = 1'b0;
      end
      if (ok) return k;
    end
    return 0;
  endfunction

  // Next-state table indexed by {s, x}, SW bits per entry, resolved entirely at elaboration
  function automatic logic [TBL_W-1:0] build_next();
    logic [TBL_W-1:0] tbl;
    logic             bb;
    int unsigned      n;
    tbl = '0;
    for (int unsigned s = 0; s < PAT_W; s++) begin
      for (int unsigned b = 0; b < 2; b++) begin
        bb = (b != 0);
        if (bb == pbit(s)) begin
          if (s < PAT_W - 1) n = s + 1;
          else               n = OVERLAP ? border() : 0;
        end else begin
          n = fallback(s, bb);
        end
        tbl = tbl | (TBL_W'(SW'(n)) << ((2 * s + b) * SW));
      end
    end
    return tbl;
  endfunction

  localparam logic [PAT_W-1:0] REV      = build_rev();
  localparam logic [TBL_W-1:0] NEXT_TBL = build_next();

  logic [SW-1:0]    s;
  logic [SW-1:0]    s_nxt;
  logic [CNT_W-1:0] cnt;
  logic             z;
  logic             e;
  logic             cnt_sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      s   <= '0;
      cnt <= '0;
    end else if (bus.clr) begin
      s   <= '0;
      cnt <= '0;
    end else if (bus.en) begin
      s <= s_nxt;
      if (z && !cnt_sat) cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    logic [PAT_W-1:0] rev_sh;
    logic [TBL_W-1:0] tbl_sh;
    logic [SW:0]      idx;
    s_nxt  = s;
    z      = 1'b0;
    rev_sh = REV >> s;
    e      = rev_sh[0];
    idx    = {s, bus.x};
    tbl_sh = NEXT_TBL >> (idx * SW);
    if (!rst && !bus.clr && bus.en) begin
      s_nxt = tbl_sh[SW-1:0];
      z     = (s == LAST) && (bus.x == e);
    end
  end

  assign cnt_sat       = &cnt;
  assign bus.z         = z;
  assign bus.match_cnt = cnt;
  assign bus.cnt_sat   = cnt_sat;
  assign bus.prefix    = s;

endmodule
